// File: rtl/register_file_sb_pkg.sv
// Shared widths and the hardwired-zero register address for decode,
// write-back and the register file itself.
package register_file_sb_pkg;

    localparam int RF_DATA_WIDTH = 16;
    localparam int RF_ADDR_WIDTH = 2;
    localparam int REG_ZERO      = 0;

    // True when the address is the hardwired zero register and that feature is on.
    function automatic logic is_zero_reg(input int addr, input bit zero_en);
        return zero_en && (addr == REG_ZERO);
    endfunction

endpackage

// File: rtl/register_file_sb_if.sv
// Decode/write-back side of the register file: two read ports, two write
// ports, destination reservation and the hazard/conflict status.
interface register_file_sb_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 2
);
    logic [ADDR_WIDTH-1:0] RS;
    logic [ADDR_WIDTH-1:0] RT;
    logic [ADDR_WIDTH-1:0] RD;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  RegWrite;
    logic [ADDR_WIDTH-1:0] RD2;
    logic [DATA_WIDTH-1:0] WriteData2;
    logic                  RegWrite2;
    logic                  ReserveEn;
    logic [ADDR_WIDTH-1:0] ReserveAddr;
    logic [DATA_WIDTH-1:0] ReadRS;
    logic [DATA_WIDTH-1:0] ReadRT;
    logic                  BusyRS;
    logic                  BusyRT;
    logic                  WriteConflict;

    modport master (
        output RS, RT, RD, WriteData, RegWrite, RD2, WriteData2, RegWrite2,
               ReserveEn, ReserveAddr,
        input  ReadRS, ReadRT, BusyRS, BusyRT, WriteConflict
    );

    modport slave (
        input  RS, RT, RD, WriteData, RegWrite, RD2, WriteData2, RegWrite2,
               ReserveEn, ReserveAddr,
        output ReadRS, ReadRT, BusyRS, BusyRT, WriteConflict
    );

endinterface

// File: rtl/register_file_sb_scoreboard.sv
// Per-register busy bits. A retiring write clears the bit, a decode
// reservation sets it; when both hit one register, set wins because a new
// producer has just been issued. Taps read the pre-edge busy state.
module rf_scoreboard
    import register_file_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter bit ZERO_REG   = 1'b0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  clr_a_en,
    input  logic [ADDR_WIDTH-1:0] clr_a_addr,
    input  logic                  clr_b_en,
    input  logic [ADDR_WIDTH-1:0] clr_b_addr,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic [ADDR_WIDTH-1:0] tap0_addr,
    input  logic [ADDR_WIDTH-1:0] tap1_addr,
    output logic                  tap0_busy,
    output logic                  tap1_busy
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Next busy vector: clears first, then set, then the zero register pinned low.
    always_comb begin
        busy_d = busy_q;
        if (clr_a_en) busy_d[clr_a_addr] = 1'b0;
        if (clr_b_en) busy_d[clr_b_addr] = 1'b0;
        if (set_en)   busy_d[set_addr]   = 1'b1;
        if (ZERO_REG) busy_d[REG_ZERO]   = 1'b0;
    end

    // Busy register, cleared asynchronously by reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Read taps come straight from the stored bits; a write in flight does not clear them early.
    always_comb begin
        tap0_busy = busy_q[tap0_addr];
        tap1_busy = busy_q[tap1_addr];
    end

endmodule

// File: rtl/register_file_sb.sv
// Parametrised dual-write register file with optional write-to-read bypass,
// optional hardwired zero register and a busy scoreboard for hazard checks.
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter bit ZERO_REG   = 1'b0,
    parameter bit BYPASS     = 1'b1
) (
    input logic               Clock,
    input logic               Reset,
    register_file_sb_if.slave rf
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic                  conflict_q;
    logic                  conflict_d;
    logic                  wr_a_en;
    logic                  wr_b_en;
    logic [DATA_WIDTH-1:0] rs_data;
    logic [DATA_WIDTH-1:0] rt_data;
    logic                  busy_rs;
    logic                  busy_rt;

    // Effective write enables: writes aimed at the hardwired zero register are dropped.
    always_comb begin
        wr_a_en = rf.RegWrite  && !is_zero_reg(int'(rf.RD),  ZERO_REG);
        wr_b_en = rf.RegWrite2 && !is_zero_reg(int'(rf.RD2), ZERO_REG);
    end

    // Next array contents; port B is applied last so it wins a same-address collision.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_a_en) regs_d[rf.RD]  = rf.WriteData;
        if (wr_b_en) regs_d[rf.RD2] = rf.WriteData2;
        // The conflict flag looks at the raw enables so a clash on register 0 still reports.
        conflict_d = rf.RegWrite && rf.RegWrite2 && (rf.RD == rf.RD2);
    end

    // Register array and the one-cycle conflict flag.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            conflict_q <= conflict_d;
        end
    end

    // Read muxes: array, then bypass (B over A), then zero-register and reset forcing.
    always_comb begin
        rs_data = regs_q[rf.RS];
        rt_data = regs_q[rf.RT];
        if (BYPASS) begin
            if (wr_a_en && (rf.RD  == rf.RS)) rs_data = rf.WriteData;
            if (wr_b_en && (rf.RD2 == rf.RS)) rs_data = rf.WriteData2;
            if (wr_a_en && (rf.RD  == rf.RT)) rt_data = rf.WriteData;
            if (wr_b_en && (rf.RD2 == rf.RT)) rt_data = rf.WriteData2;
        end
        // Reads during reset must not forward a write that reset is about to discard.
        if (is_zero_reg(int'(rf.RS), ZERO_REG) || Reset) rs_data = '0;
        if (is_zero_reg(int'(rf.RT), ZERO_REG) || Reset) rt_data = '0;
    end

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .Clock      (Clock),
        .Reset      (Reset),
        .clr_a_en   (rf.RegWrite),
        .clr_a_addr (rf.RD),
        .clr_b_en   (rf.RegWrite2),
        .clr_b_addr (rf.RD2),
        .set_en     (rf.ReserveEn),
        .set_addr   (rf.ReserveAddr),
        .tap0_addr  (rf.RS),
        .tap1_addr  (rf.RT),
        .tap0_busy  (busy_rs),
        .tap1_busy  (busy_rt)
    );

    assign rf.ReadRS        = rs_data;
    assign rf.ReadRT        = rt_data;
    assign rf.BusyRS        = busy_rs;
    assign rf.BusyRT        = busy_rt;
    assign rf.WriteConflict = conflict_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: three instances share one stimulus
// stream (bypass on, bypass off, zero register on) and are checked against
// hand-computed values.
module tb_register_file_sb;

    localparam int DW = 16;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] rs, rt, rd, rd2, res_addr;
    logic [DW-1:0] wd, wd2;
    logic          we, we2, res_en;

    int checks = 0;
    int errors = 0;

    register_file_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_byp ();
    register_file_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_nob ();
    register_file_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_zr ();

    assign if_byp.RS = rs;   assign if_nob.RS = rs;   assign if_zr.RS = rs;
    assign if_byp.RT = rt;   assign if_nob.RT = rt;   assign if_zr.RT = rt;
    assign if_byp.RD = rd;   assign if_nob.RD = rd;   assign if_zr.RD = rd;
    assign if_byp.RD2 = rd2; assign if_nob.RD2 = rd2; assign if_zr.RD2 = rd2;
    assign if_byp.WriteData = wd;   assign if_nob.WriteData = wd;   assign if_zr.WriteData = wd;
    assign if_byp.WriteData2 = wd2; assign if_nob.WriteData2 = wd2; assign if_zr.WriteData2 = wd2;
    assign if_byp.RegWrite = we;    assign if_nob.RegWrite = we;    assign if_zr.RegWrite = we;
    assign if_byp.RegWrite2 = we2;  assign if_nob.RegWrite2 = we2;  assign if_zr.RegWrite2 = we2;
    assign if_byp.ReserveEn = res_en;     assign if_nob.ReserveEn = res_en;     assign if_zr.ReserveEn = res_en;
    assign if_byp.ReserveAddr = res_addr; assign if_nob.ReserveAddr = res_addr; assign if_zr.ReserveAddr = res_addr;

    register_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b0), .BYPASS(1'b1))
        dut_byp (.Clock(clk), .Reset(rst), .rf(if_byp));
    register_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b0), .BYPASS(1'b0))
        dut_nob (.Clock(clk), .Reset(rst), .rf(if_nob));
    register_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1), .BYPASS(1'b1))
        dut_zr (.Clock(clk), .Reset(rst), .rf(if_zr));

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic drive_idle();
        we = 1'b0; we2 = 1'b0; res_en = 1'b0;
        rd = '0; rd2 = '0; wd = '0; wd2 = '0; res_addr = '0;
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        rs = 2'd0; rt = 2'd1;
        rst = 1'b1;
        post_edge();
        checks++; if (if_byp.ReadRS !== 16'h0000) begin errors++; $display("FAIL reset_rs: got %h want 0000", if_byp.ReadRS); end
        checks++; if (if_byp.ReadRT !== 16'h0000) begin errors++; $display("FAIL reset_rt: got %h want 0000", if_byp.ReadRT); end
        checks++; if (if_byp.BusyRS !== 1'b0 || if_byp.BusyRT !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b%b want 00", if_byp.BusyRS, if_byp.BusyRT); end
        checks++; if (if_byp.WriteConflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b want 0", if_byp.WriteConflict); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        @(negedge clk); we = 1'b1; rd = 2'd2; wd = 16'h0005;
        @(negedge clk); rd = 2'd3; wd = 16'h0007;
        @(negedge clk); drive_idle(); rs = 2'd2; rt = 2'd3;
        #1;
        checks++; if (if_byp.ReadRS !== 16'h0005) begin errors++; $display("FAIL wr_rs_byp: got %h want 0005", if_byp.ReadRS); end
        checks++; if (if_byp.ReadRT !== 16'h0007) begin errors++; $display("FAIL wr_rt_byp: got %h want 0007", if_byp.ReadRT); end
        checks++; if (if_nob.ReadRS !== 16'h0005 || if_nob.ReadRT !== 16'h0007) begin errors++; $display("FAIL wr_nob: got %h %h want 0005 0007", if_nob.ReadRS, if_nob.ReadRT); end
    endtask

    task automatic test_dual_write();
        @(negedge clk);
        we = 1'b1; rd = 2'd1; wd = 16'h1111;
        we2 = 1'b1; rd2 = 2'd1; wd2 = 16'h2222;
        rs = 2'd1;
        #1;
        checks++; if (if_byp.ReadRS !== 16'h2222) begin errors++; $display("FAIL dual_bypass_b: got %h want 2222", if_byp.ReadRS); end
        checks++; if (if_nob.ReadRS !== 16'h0000) begin errors++; $display("FAIL dual_nob_pre: got %h want 0000", if_nob.ReadRS); end
        post_edge();
        checks++; if (if_byp.WriteConflict !== 1'b1) begin errors++; $display("FAIL dual_conflict_set: got %b want 1", if_byp.WriteConflict); end
        @(negedge clk); drive_idle();
        #1;
        checks++; if (if_nob.ReadRS !== 16'h2222) begin errors++; $display("FAIL dual_b_wins: got %h want 2222", if_nob.ReadRS); end
        post_edge();
        checks++; if (if_byp.WriteConflict !== 1'b0) begin errors++; $display("FAIL dual_conflict_clear: got %b want 0", if_byp.WriteConflict); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        rs = 2'd3; rt = 2'd3;
        we = 1'b1; rd = 2'd3; wd = 16'hBEEF;
        #1;
        checks++; if (if_byp.ReadRS !== 16'hBEEF) begin errors++; $display("FAIL byp_a_rs: got %h want beef", if_byp.ReadRS); end
        checks++; if (if_nob.ReadRS !== 16'h0007) begin errors++; $display("FAIL nob_a_rs: got %h want 0007", if_nob.ReadRS); end
        #1;
        we2 = 1'b1; rd2 = 2'd3; wd2 = 16'hCAFE;
        #1;
        checks++; if (if_byp.ReadRT !== 16'hCAFE) begin errors++; $display("FAIL byp_b_prio_rt: got %h want cafe", if_byp.ReadRT); end
        checks++; if (if_nob.ReadRT !== 16'h0007) begin errors++; $display("FAIL nob_b_rt: got %h want 0007", if_nob.ReadRT); end
        post_edge();
        checks++; if (if_nob.ReadRS !== 16'hCAFE) begin errors++; $display("FAIL nob_after_edge: got %h want cafe", if_nob.ReadRS); end
        @(negedge clk); drive_idle();
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        rs = 2'd2; rt = 2'd2;
        res_en = 1'b1; res_addr = 2'd2;
        #1;
        checks++; if (if_byp.BusyRS !== 1'b0) begin errors++; $display("FAIL sb_pre_reserve: got %b want 0", if_byp.BusyRS); end
        post_edge();
        checks++; if (if_byp.BusyRS !== 1'b1 || if_byp.BusyRT !== 1'b1) begin errors++; $display("FAIL sb_reserved: got %b%b want 11", if_byp.BusyRS, if_byp.BusyRT); end
        @(negedge clk);
        res_en = 1'b0; we = 1'b1; rd = 2'd2; wd = 16'h0055;
        #1;
        checks++; if (if_byp.BusyRS !== 1'b1) begin errors++; $display("FAIL sb_no_early_clear: got %b want 1", if_byp.BusyRS); end
        post_edge();
        checks++; if (if_byp.BusyRS !== 1'b0) begin errors++; $display("FAIL sb_write_clear: got %b want 0", if_byp.BusyRS); end
        @(negedge clk);
        wd = 16'h0005; res_en = 1'b1; res_addr = 2'd2;
        post_edge();
        @(negedge clk); drive_idle();
        #1;
        checks++; if (if_byp.BusyRS !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %b want 1", if_byp.BusyRS); end
        checks++; if (if_byp.ReadRS !== 16'h0005) begin errors++; $display("FAIL sb_set_wins_data: got %h want 0005", if_byp.ReadRS); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        rs = 2'd2; rt = 2'd2;
        we = 1'b1; rd = 2'd2; wd = 16'h0077;
        res_en = 1'b1; res_addr = 2'd1;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (if_byp.ReadRS !== 16'h0000) begin errors++; $display("FAIL arst_rs: got %h want 0000", if_byp.ReadRS); end
        checks++; if (if_byp.BusyRS !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", if_byp.BusyRS); end
        checks++; if (if_nob.ReadRT !== 16'h0000) begin errors++; $display("FAIL arst_nob_rt: got %h want 0000", if_nob.ReadRT); end
        post_edge();
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        rs = 2'd2; rt = 2'd1;
        post_edge();
        checks++; if (if_byp.ReadRS !== 16'h0000 || if_byp.ReadRT !== 16'h0000) begin errors++; $display("FAIL arst_cleared: got %h %h want 0000 0000", if_byp.ReadRS, if_byp.ReadRT); end
        checks++; if (if_byp.BusyRS !== 1'b0 || if_byp.BusyRT !== 1'b0) begin errors++; $display("FAIL arst_busy_lost: got %b%b want 00", if_byp.BusyRS, if_byp.BusyRT); end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        rs = 2'd0; rt = 2'd0;
        we = 1'b1; rd = 2'd0; wd = 16'h0009;
        res_en = 1'b1; res_addr = 2'd0;
        #1;
        checks++; if (if_zr.ReadRS !== 16'h0000) begin errors++; $display("FAIL zr_no_bypass: got %h want 0000", if_zr.ReadRS); end
        checks++; if (if_byp.ReadRS !== 16'h0009) begin errors++; $display("FAIL nz_bypass_r0: got %h want 0009", if_byp.ReadRS); end
        post_edge();
        @(negedge clk); drive_idle();
        #1;
        checks++; if (if_zr.ReadRS !== 16'h0000 || if_zr.BusyRS !== 1'b0) begin errors++; $display("FAIL zr_read: got %h busy %b want 0000 busy 0", if_zr.ReadRS, if_zr.BusyRS); end
        checks++; if (if_zr.BusyRT !== 1'b0) begin errors++; $display("FAIL zr_busy_rt: got %b want 0", if_zr.BusyRT); end
        checks++; if (if_nob.ReadRS !== 16'h0009 || if_nob.BusyRS !== 1'b1) begin errors++; $display("FAIL nz_r0: got %h busy %b want 0009 busy 1", if_nob.ReadRS, if_nob.BusyRS); end
        we = 1'b1; rd = 2'd0; wd = 16'h0001;
        we2 = 1'b1; rd2 = 2'd0; wd2 = 16'h0002;
        post_edge();
        checks++; if (if_zr.WriteConflict !== 1'b1) begin errors++; $display("FAIL zr_conflict: got %b want 1", if_zr.WriteConflict); end
        @(negedge clk); drive_idle();
        #1;
        checks++; if (if_zr.ReadRT !== 16'h0000) begin errors++; $display("FAIL zr_after_dual: got %h want 0000", if_zr.ReadRT); end
        checks++; if (if_nob.ReadRT !== 16'h0002) begin errors++; $display("FAIL nz_after_dual: got %h want 0002", if_nob.ReadRT); end
        post_edge();
        checks++; if (if_zr.WriteConflict !== 1'b0) begin errors++; $display("FAIL zr_conflict_clear: got %b want 0", if_zr.WriteConflict); end
    endtask

    initial begin
        drive_idle();
        rs = '0; rt = '0;
        test_reset();
        test_write_read();
        test_dual_write();
        test_bypass();
        test_scoreboard();
        test_async_reset();
        test_zero_reg();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
